// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
// Gray/binary helpers operate on a wide word; callers cast to their width.
package fifo_pkg;

  localparam int unsigned PTR_WIDTH_DEF = 3;
  localparam int unsigned PTR_MAXW = 32;

  typedef logic [PTR_MAXW-1:0] ptr_max_t;

  // Zero extension is harmless for both directions of the conversion.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_if.sv
// Write-side bundle between producer/synchroniser and the
// write pointer controller.
interface fifo_wptr_ctrl_if #(
  parameter int unsigned PTR_WIDTH = 3
);

  logic                 w_en;
  logic [PTR_WIDTH:0]   g_rptr_sync;
  logic                 ovf_clr;
  logic                 mem_w_en;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wr_level;
  logic                 overflow;

  modport master (
    output w_en,
    output g_rptr_sync,
    output ovf_clr,
    input  mem_w_en,
    input  b_wptr,
    input  g_wptr,
    input  full,
    input  almost_full,
    input  wr_level,
    input  overflow
  );

  modport slave (
    input  w_en,
    input  g_rptr_sync,
    input  ovf_clr,
    output mem_w_en,
    output b_wptr,
    output g_wptr,
    output full,
    output almost_full,
    output wr_level,
    output overflow
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Shared by the write- and read-side pointer controllers.
module fifo_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic [W-1:0] b;

  always_comb begin
    b = '0;
    b[W-1] = gray_i[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray_i[i];
    end
    bin_o = b;
  end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer/flag controller for the dual-clock FIFO.
// All flags are registered; g_wptr comes straight from a flop.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH    = PTR_WIDTH_DEF,
  parameter int unsigned AFULL_THRESH = (1 << PTR_WIDTH) - 1
) (
  input  logic             wclk,
  input  logic             wrst,
  fifo_wptr_ctrl_if.slave  bus
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  typedef logic [PTR_WIDTH:0] ptr_t;

  ptr_t b_wptr_q, b_wptr_d;
  ptr_t g_wptr_q, g_wptr_d;
  ptr_t lvl_q, lvl_d;
  ptr_t rptr_bin;
  ptr_t rptr_full;
  logic full_q, full_d;
  logic af_q, af_d;
  logic ovf_q, ovf_d;
  logic wr_ok;

  assign wr_ok = bus.w_en & ~full_q & ~wrst;

  fifo_gray2bin #(
    .W (PW)
  ) u_g2b (
    .gray_i (bus.g_rptr_sync),
    .bin_o  (rptr_bin)
  );

  // Full when write pointer is one lap ahead: top two Gray bits inverted.
  assign rptr_full = {~bus.g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                      bus.g_rptr_sync[PTR_WIDTH-2:0]};

  always_comb begin
    b_wptr_d = b_wptr_q + ptr_t'(wr_ok);
    g_wptr_d = ptr_t'(bin2gray(ptr_max_t'(b_wptr_d)));
    full_d   = (g_wptr_d == rptr_full);
    lvl_d    = b_wptr_d - rptr_bin;
    af_d     = (32'(lvl_d) >= AFULL_THRESH);
    ovf_d    = (bus.w_en & full_q) | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      lvl_q    <= lvl_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.mem_w_en    = wr_ok;
  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.wr_level    = lvl_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl (PTR_WIDTH=3).
// Driver queues expected outputs per cycle; monitor checks at negedge.
module tb_fifo_wptr_ctrl;

  typedef struct {
    string      nm;
    logic       mem;
    logic [3:0] b;
    logic [3:0] g;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wptr_ctrl_if #(.PTR_WIDTH(3)) bus ();

  fifo_wptr_ctrl #(
    .PTR_WIDTH    (3),
    .AFULL_THRESH (7)
  ) dut (
    .wclk (clk),
    .wrst (rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0] gray_tab [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  function automatic exp_t mk(string nm, bit mem, int b,
                              int lvl, bit full, bit af, bit ovf);
    exp_t e;
    e.nm   = nm;
    e.mem  = mem;
    e.b    = 4'(b);
    e.g    = gray_tab[b & 15];
    e.full = full;
    e.af   = af;
    e.lvl  = 4'(lvl);
    e.ovf  = ovf;
    return e;
  endfunction

  task automatic chk(string nm, string f, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %b want %b", nm, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "mem_w_en", 4'(bus.mem_w_en), 4'(e.mem));
      chk(e.nm, "b_wptr", bus.b_wptr, e.b);
      chk(e.nm, "g_wptr", bus.g_wptr, e.g);
      chk(e.nm, "full", 4'(bus.full), 4'(e.full));
      chk(e.nm, "almost_full", 4'(bus.almost_full), 4'(e.af));
      chk(e.nm, "wr_level", bus.wr_level, e.lvl);
      chk(e.nm, "overflow", 4'(bus.overflow), 4'(e.ovf));
    end
  end

  task automatic step(bit r, bit we, logic [3:0] gr, bit clr, exp_t e);
    @(posedge clk);
    #1;
    rst             = r;
    bus.w_en        = we;
    bus.g_rptr_sync = gr;
    bus.ovf_clr     = clr;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.w_en        = 1'b0;
    bus.g_rptr_sync = 4'b0000;
    bus.ovf_clr     = 1'b0;

    step(1, 0, 4'b0000, 0, mk("rst", 0, 0, 0, 0, 0, 0));
    step(0, 0, 4'b0000, 0, mk("idle", 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < 8; k++) begin
      step(0, 1, 4'b0000, 0,
           mk($sformatf("fill%0d", k), 1, k, k, 0, k >= 7, 0));
    end

    step(0, 1, 4'b0000, 0, mk("ovf1", 0, 8, 8, 1, 1, 0));
    step(0, 1, 4'b0000, 0, mk("ovf2", 0, 8, 8, 1, 1, 1));
    step(0, 0, 4'b0000, 1, mk("clr1", 0, 8, 8, 1, 1, 1));
    step(0, 1, 4'b0000, 1, mk("clr_we", 0, 8, 8, 1, 1, 0));
    step(0, 0, 4'b0000, 0, mk("ovf_hold", 0, 8, 8, 1, 1, 1));
    step(0, 0, 4'b0000, 1, mk("clr2", 0, 8, 8, 1, 1, 1));

    step(0, 0, 4'b0010, 0, mk("drain0", 0, 8, 8, 1, 1, 0));
    step(0, 1, 4'b0010, 0, mk("drain1", 1, 8, 5, 0, 0, 0));
    step(0, 0, 4'b0010, 0, mk("drain2", 0, 9, 6, 0, 0, 0));
    step(0, 0, 4'b0111, 0, mk("lag4", 0, 9, 6, 0, 0, 0));

    for (int k = 9; k <= 16; k++) begin
      step(0, 1, gray_tab[(k - 3) & 15], 0,
           mk($sformatf("wrap%0d", k & 15), 1, k & 15, 4, 0, 0, 0));
    end
    step(0, 0, 4'b1011, 0, mk("wrap_end", 0, 1, 4, 0, 0, 0));

    step(0, 1, 4'b1011, 0, mk("sim1", 1, 1, 4, 0, 0, 0));
    step(0, 1, 4'b1011, 0, mk("sim2", 1, 2, 5, 0, 0, 0));
    step(0, 1, 4'b1011, 0, mk("sim3", 1, 3, 6, 0, 0, 0));
    step(0, 1, 4'b1001, 0, mk("sim4", 1, 4, 7, 0, 1, 0));
    step(0, 0, 4'b1001, 0, mk("sim5", 0, 5, 7, 0, 1, 0));

    step(0, 1, 4'b1001, 0, mk("burst", 1, 5, 7, 0, 1, 0));
    step(1, 1, 4'b1001, 0, mk("rst_mid", 0, 0, 0, 0, 0, 0));
    step(1, 1, 4'b1001, 0, mk("rst_hold", 0, 0, 0, 0, 0, 0));
    step(0, 0, 4'b0000, 0, mk("rst_rel", 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
